// File: rtl/com_pkg.sv
// Shared definitions for the collect-link com blocks.
//   state_t      : one-hot receive parser state encoding
//   SYNC0/SYNC1  : two-byte frame sync pattern
//   BTYPE_*      : frame type codes shared by rx, control and tx blocks
package com_pkg;

    typedef enum logic [7:0] {
        ST_IDLE = 8'b0000_0001,
        ST_SYNC = 8'b0000_0010,
        ST_HEAD = 8'b0000_0100,
        ST_LEN  = 8'b0000_1000,
        ST_DATA = 8'b0001_0000,
        ST_CHK  = 8'b0010_0000,
        ST_HOLD = 8'b0100_0000,
        ST_DONE = 8'b1000_0000
    } state_t;

    localparam logic [7:0] SYNC0 = 8'h55;
    localparam logic [7:0] SYNC1 = 8'hAA;

    localparam logic [3:0] BTYPE_INIT = 4'h0;
    localparam logic [3:0] BTYPE_INFO = 4'h1;
    localparam logic [3:0] BTYPE_DATA = 4'hE;

endpackage

// File: rtl/com_rx_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data   : synchronous write port
//   rd_addr, rd_data  : read port, registered, one cycle latency
module com_rx_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_reg;

    // Array contents are never reset so the write port maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/com_rx_frame.sv
// Receive frame parser: hunts for 55 AA, parses HDR/LEN/payload/CHK,
// buffers the payload and holds a good frame until fd_com_read.
//   rx_data/rx_vld      : byte stream from the deserializer
//   fs_com_read         : level, a good frame is held
//   fd_com_read         : consumer has taken the frame
//   com_rx_btype/idx/len: fields of the held frame
//   buf_addr/buf_data   : payload read port, 1-cycle latency
//   err_cnt/ovr_cnt     : saturating dropped-frame / dropped-byte counts
module com_rx_frame
    import com_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 450,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_vld,
    output logic          fs_com_read,
    input  logic          fd_com_read,
    output logic [3:0]    com_rx_btype,
    output logic [3:0]    com_rx_idx,
    output logic [7:0]    com_rx_len,
    input  logic [AW-1:0] buf_addr,
    output logic [7:0]    buf_data,
    output logic [7:0]    err_cnt,
    output logic [7:0]    ovr_cnt
);

    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    state_t        state_reg, state_next;
    logic [GW-1:0] gap_reg;
    logic [7:0]    hdr_reg, len_reg, xor_reg, wr_ptr_reg;
    logic [3:0]    btype_reg, idx_reg;
    logic [7:0]    len_out_reg, err_cnt_reg, ovr_cnt_reg;

    logic timed, err_inc, ovr_inc, accept, wr_en;

    always_comb begin
        state_next = state_reg;
        err_inc    = 1'b0;
        ovr_inc    = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        timed      = (state_reg == ST_SYNC) || (state_reg == ST_HEAD) ||
                     (state_reg == ST_LEN)  || (state_reg == ST_DATA) ||
                     (state_reg == ST_CHK);
        if (timed && !rx_vld && gap_reg == GAP_LAST) begin
            // A lone sync byte followed by silence is line noise, not a frame.
            state_next = ST_IDLE;
            err_inc    = (state_reg != ST_SYNC);
        end else begin
            unique case (state_reg)
                ST_IDLE: if (rx_vld && rx_data == SYNC0) state_next = ST_SYNC;
                ST_SYNC: if (rx_vld) begin
                    if (rx_data == SYNC1)      state_next = ST_HEAD;
                    else if (rx_data != SYNC0) state_next = ST_IDLE;
                end
                ST_HEAD: if (rx_vld) state_next = ST_LEN;
                ST_LEN: if (rx_vld) begin
                    if (rx_data > LEN_MAX) begin
                        err_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (rx_data == 8'h00) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
                ST_DATA: if (rx_vld) begin
                    wr_en = 1'b1;
                    if (wr_ptr_reg + 8'd1 == len_reg) state_next = ST_CHK;
                end
                ST_CHK: if (rx_vld) begin
                    if (rx_data == xor_reg) begin
                        accept     = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        err_inc    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    ovr_inc = rx_vld;
                    if (fd_com_read) state_next = ST_DONE;
                end
                ST_DONE: begin
                    ovr_inc    = rx_vld;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gap_reg     <= '0;
            hdr_reg     <= 8'h00;
            len_reg     <= 8'h00;
            xor_reg     <= 8'h00;
            wr_ptr_reg  <= 8'h00;
            btype_reg   <= 4'h0;
            idx_reg     <= 4'h0;
            len_out_reg <= 8'h00;
            err_cnt_reg <= 8'h00;
            ovr_cnt_reg <= 8'h00;
        end else begin
            state_reg <= state_next;

            if (!timed || rx_vld) gap_reg <= '0;
            else                  gap_reg <= gap_reg + 1'b1;

            if (rx_vld) begin
                unique case (state_reg)
                    ST_HEAD: begin
                        hdr_reg    <= rx_data;
                        xor_reg    <= rx_data;
                        wr_ptr_reg <= 8'h00;
                    end
                    ST_LEN: begin
                        len_reg <= rx_data;
                        xor_reg <= xor_reg ^ rx_data;
                    end
                    ST_DATA: begin
                        xor_reg    <= xor_reg ^ rx_data;
                        wr_ptr_reg <= wr_ptr_reg + 8'd1;
                    end
                    default: ;
                endcase
            end

            if (accept) begin
                btype_reg   <= hdr_reg[7:4];
                idx_reg     <= hdr_reg[3:0];
                len_out_reg <= len_reg;
            end

            if (err_inc && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
            if (ovr_inc && ovr_cnt_reg != 8'hFF) ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
        end
    end

    com_rx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (buf_addr),
        .rd_data (buf_data)
    );

    assign fs_com_read  = (state_reg == ST_HOLD);
    assign com_rx_btype = btype_reg;
    assign com_rx_idx   = idx_reg;
    assign com_rx_len   = len_out_reg;
    assign err_cnt      = err_cnt_reg;
    assign ovr_cnt      = ovr_cnt_reg;

endmodule

// File: doc/com_rx_frame.md
# com_rx_frame

Receive-side frame parser for the collect link. It sits between the byte deserializer and the com control state machine. It hunts for a sync pattern, checks the header, length, payload and checksum, and buffers the payload. On a good frame it raises `fs_com_read` with the frame's btype and index, then holds the frame until the control block acknowledges it with `fd_com_read`.

## Interface
- `MAX_LEN`, default 16: payload buffer depth in bytes; largest accepted LEN.
- `TIMEOUT`, default 450: maximum inter-byte gap in clk cycles inside a frame (6 us).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; synchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_vld`  in  1  one-cycle strobe; `rx_data` is valid.
- `fs_com_read`  out  1  level; a good frame is held.
- `fd_com_read`  in  1  consumer has taken the frame.
- `com_rx_btype`  out  4  btype of the held frame.
- `com_rx_idx`  out  4  data index of the held frame.
- `com_rx_len`  out  8  payload length of the held frame.
- `buf_addr`  in  log2(MAX_LEN)  payload read address.
- `buf_data`  out  8  payload byte; registered, 1-cycle read latency.
- `err_cnt`  out  8  saturating count of dropped frames (checksum, length, timeout).
- `ovr_cnt`  out  8  saturating count of bytes dropped while holding a frame.

## Operation
- Frame format: 0x55, 0xAA, HDR = {btype[7:4], idx[3:0]}, LEN, LEN payload bytes, CHK.
- CHK = XOR of HDR, LEN and all payload bytes.
- State register is one-hot. All transitions below are on a cycle with `rx_vld` = 1 unless stated otherwise.
- IDLE: 0x55 -> SYNC; any other byte -> stay.
- SYNC: 0xAA -> HEAD; 0x55 -> stay in SYNC (re-sync); any other byte -> IDLE.
- HEAD: capture HDR, seed the running XOR with it -> LEN.
- LEN:
  - LEN > MAX_LEN -> increment `err_cnt`, go to IDLE.
  - LEN = 0 -> CHK.
  - otherwise -> DATA.
- DATA: write the byte to buffer[wr_ptr], XOR it in, increment wr_ptr; after the LEN-th byte -> CHK.
- CHK:
  - byte == running XOR -> latch btype, idx and len into the output registers; go to HOLD.
  - mismatch -> increment `err_cnt`, go to IDLE.
- HOLD: `fs_com_read` = 1. When `fd_com_read` = 1 -> DONE.
- DONE: `fs_com_read` = 0 for one cycle -> IDLE, regardless of `fd_com_read`.
- Timeout:
  - Applies in SYNC, HEAD, LEN, DATA and CHK.
  - `gap_cnt` increments on each cycle with no `rx_vld` and clears on `rx_vld`.
  - When `gap_cnt` = TIMEOUT-1 and `rx_vld` = 0 -> increment `err_cnt`, go to IDLE.
  - If `rx_vld` arrives in that same cycle, the byte is processed and there is no timeout.
  - A timeout in SYNC is not counted as an error.
- Bytes arriving in HOLD or DONE are discarded and `ovr_cnt` increments. The buffer and the output registers are untouched.
- `com_rx_btype`, `com_rx_idx` and `com_rx_len` update only on CHK success and are stable throughout HOLD.
- Both counters saturate at 0xFF.
- Reset: all outputs are 0, the state is IDLE, and wr_ptr, the XOR register and both counters are cleared. A reset mid-frame or in HOLD discards the frame. Buffer contents are not cleared.

## Timing
- CHK byte accepted at cycle N -> `fs_com_read` = 1 at N+1.
- `fd_com_read` sampled high at cycle M -> `fs_com_read` = 0 at M+1. The earliest new frame byte is accepted at M+2, in IDLE.
- The payload is valid in the buffer from the cycle `fs_com_read` rises until DONE exits. `buf_data` reflects `buf_addr` from the previous cycle.
- Maximum throughput: one byte per cycle.

## Structure
- Package `com_pkg` holds:
  - the one-hot state encoding;
  - SYNC0 = 8'h55 and SYNC1 = 8'hAA;
  - the BTYPE constants (INIT 0x0, INFO 0x1, DATA 0xE), shared with the control and transmit blocks.
- Sub-module `com_rx_buf`: MAX_LEN x 8 simple dual-port RAM, synchronous write, registered read.

## Test plan
- Good frame 55 AA 1E 03 11 22 33 CHK=1E^03^11^22^33 -> `fs_com_read`=1 one cycle after CHK, btype=1, idx=E, len=3, buf[0..2]=11,22,33. Pulse `fd_com_read` -> `fs_com_read`=0 next cycle.
- Same frame with CHK corrupted -> `fs_com_read` stays 0, `err_cnt`=1, and the next good frame is accepted.
- Stream 00 55 55 AA E5 00 CHK=E5 (LEN=0) -> btype=E, idx=5, len=0, frame accepted.
- LEN=MAX_LEN+1 -> `err_cnt`+1, return to IDLE. A gap of TIMEOUT cycles after HEAD -> `err_cnt`+1. A gap of TIMEOUT-1 cycles -> frame still accepted.
- Hold a frame with `fd_com_read`=0 and send 5 bytes -> `ovr_cnt`=5, outputs and buffer unchanged.
- Assert `rst` mid-DATA -> all outputs 0 next cycle. A following good frame is parsed correctly.
